// File: rtl/bit_pattern_gen.sv
// Serial bit-pattern transmitter: accepts a WIDTH-bit word over valid/ready and
// shifts it out MSB first, repeating the frame in_reps+1 times with GAP idle cycles between.
module bit_pattern_gen #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pattern,
    input  logic [REP_W-1:0] in_reps,
    input  logic             abort,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP > 0 ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] hold;
    logic [REP_W-1:0] rep_cnt;
    logic [IW-1:0]    bit_idx;
    logic [3:0]       gap_cnt;

    assign in_ready = (state == S_IDLE) && !abort && reset_n;

    // Outputs are registered alongside the state: bit_idx names the bit currently on sout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            sreg       <= '0;
            hold       <= '0;
            rep_cnt    <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sof        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        sreg       <= in_pattern << 1;
                        hold       <= in_pattern;
                        rep_cnt    <= in_reps;
                        bit_idx    <= LAST_IDX;
                        sout       <= in_pattern[WIDTH-1];
                        sout_valid <= 1'b1;
                        sof        <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state      <= S_IDLE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        sof        <= 1'b0;
                        busy       <= 1'b0;
                    end else if (bit_idx == '0) begin
                        if (rep_cnt == '0) begin
                            state      <= S_IDLE;
                            sout       <= 1'b0;
                            sout_valid <= 1'b0;
                            sof        <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt - 1'b1;
                            if (GAP == 0) begin
                                sreg       <= hold << 1;
                                bit_idx    <= LAST_IDX;
                                sout       <= hold[WIDTH-1];
                                sout_valid <= 1'b1;
                                sof        <= 1'b1;
                            end else begin
                                state      <= S_GAP;
                                gap_cnt    <= GAP_LAST;
                                sout       <= 1'b0;
                                sout_valid <= 1'b0;
                                sof        <= 1'b0;
                            end
                        end
                    end else begin
                        sreg    <= sreg << 1;
                        bit_idx <= bit_idx - 1'b1;
                        sout    <= sreg[WIDTH-1];
                        sof     <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state      <= S_SHIFT;
                        sreg       <= hold << 1;
                        bit_idx    <= LAST_IDX;
                        sout       <= hold[WIDTH-1];
                        sout_valid <= 1'b1;
                        sof        <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    sof        <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bit_pattern_gen.md
# bit_pattern_gen

Serial bit-pattern transmitter. It accepts a WIDTH-bit pattern word over a valid/ready handshake and shifts it out MSB first, one bit per clock, as a serial stream with qualifier and frame markers. It can repeat the frame a programmed number of times with a fixed idle gap between frames. It drives the serial input of the team's bit-pattern detector, so it serves as the stimulus source for that block and as its system-level counterpart.

## Interface
- WIDTH, 4: pattern length in bits, legal 2..32
- GAP, 0: idle cycles between repeated frames, legal 0..15
- REP_W, 4: width of the repeat-count field
- clk  input  1  single clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  pattern word offered
- in_ready  output  1  block can accept a word this cycle
- in_pattern  input  WIDTH  pattern to transmit, bit WIDTH-1 sent first
- in_reps  input  REP_W  extra repetitions; frames sent = in_reps+1
- abort  input  1  synchronous abort of the current job
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a pattern bit this cycle
- sof  output  1  high on the first bit of every frame
- busy  output  1  job in progress (SHIFT or GAP)
- done  output  1  one-cycle pulse after the last bit of the final frame

## Operation
- States: IDLE, SHIFT, GAP. Reset forces IDLE.
- in_ready is combinational: high only when state is IDLE, abort=0 and reset_n=1.
- **IDLE:** when in_valid and in_ready are both high at an edge, the block latches in_pattern into the shift register and into a hold register, loads the rep counter with in_reps, and moves to SHIFT with the bit index at WIDTH-1.
- **SHIFT:** each cycle presents the current MSB on sout with sout_valid=1, shifts left, and decrements the bit index. sof=1 only when the bit index is WIDTH-1.
- **End of frame** (the last bit has been presented):
  - If the rep counter is 0, go to IDLE and pulse done.
  - Otherwise decrement the rep counter and reload the shift register from the hold register.
  - With GAP=0 the next edge starts the next frame directly, with no bubble.
  - With GAP>0 the block enters GAP for exactly GAP cycles (sout_valid=0), then returns to SHIFT.
- abort=1 in SHIFT or GAP: go to IDLE at the next edge. No done pulse; partial frame is discarded. abort in IDLE only suppresses acceptance.
- in_valid while busy is ignored, since in_ready=0. The pattern is never re-sampled mid-job.
- sout is 0 whenever sout_valid=0.
- busy=1 exactly in SHIFT and GAP.
- Rep counter is REP_W bits and never wraps. in_reps all-ones gives 2^REP_W frames.

## Timing
- All outputs except in_ready are registered.
- Reset value of every output: sout=0, sout_valid=0, sof=0, busy=0, done=0, in_ready=0.
- Outputs go to their reset values immediately when reset_n falls; the block is in IDLE at the first edge after release.
- Latency: word accepted at edge N → first bit on sout from edge N through edge N+1.
- One frame occupies WIDTH consecutive cycles.
- A job lasts (in_reps+1)·WIDTH + in_reps·GAP cycles.
- done is high during the single cycle after the last bit. The block is in IDLE during that cycle, so in_ready=1 and a new word can be accepted in the same cycle.
- Back-to-back jobs therefore have exactly one cycle with sout_valid=0 between them.
- Reset asserted mid-frame aborts immediately. No done pulse and no residual bits after release.

## Test plan
- WIDTH=4, GAP=0: accept 4'b1011, reps 0 → sout 1,0,1,1 on 4 consecutive cycles with sout_valid=1; sof on the first bit only; done on the 5th cycle; busy high for 4 cycles.
- WIDTH=4, GAP=2: accept 4'b1101, reps 2 → three frames 1101 with 2 sout_valid=0 cycles between them; 16 busy cycles total; sof 3 times; done exactly once.
- Back-to-back: in_valid held high with 4'b1011 then 4'b0110 → second word accepted in the done cycle; its first bit 0 appears the next cycle; exactly one idle cycle between frames.
- Abort asserted while the 2nd bit of 4'b1011 is on sout → sout_valid=0 and busy=0 from the next cycle; no done; in_ready=1 after abort drops.
- reset_n driven low during the 3rd bit of a repeating job → all outputs 0 within the same cycle; after release, IDLE with in_ready=1 and no further bits.
- in_valid pulsed with 4'b0001 while busy → ignored (in_ready=0); the original pattern completes unchanged. Then reps=all-ones with WIDTH=2 → exactly 16 frames.
